// File: rtl/timer.sv
// DMG-style DIV/TIMA/TMA/TAC timer with falling-edge tick detection and interrupt request.
// Optional macro TIMER_OVF_DELAY_EN adds the 4-clock overflow window before the TMA reload.
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  d_wr,
    output logic [7:0]  d_rd,
    input  logic        rd,
    input  logic        wr,
    output logic        int_tim_req,
    input  logic        int_tim_ack
);
    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    logic [15:0] div_cnt_reg;
    logic [7:0]  tima_reg;
    logic [7:0]  tima_next;
    logic [7:0]  tma_reg;
    logic [2:0]  tac_reg;
    logic        tick_reg;
    logic        tick_sig;
    logic        tick_fall;
    logic        tap_bit;
    logic        int_req_reg;
    logic        int_req_next;
    logic        reload;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;

    // Reads are side-effect free, so the strobe carries no information here.
    logic        unused_rd;
    assign unused_rd = rd;

    assign wr_div  = wr && (a == ADDR_DIV);
    assign wr_tima = wr && (a == ADDR_TIMA);
    assign wr_tma  = wr && (a == ADDR_TMA);
    assign wr_tac  = wr && (a == ADDR_TAC);

    always_comb begin
        tap_bit = div_cnt_reg[9];
        case (tac_reg[1:0])
            2'b00:   tap_bit = div_cnt_reg[9];
            2'b01:   tap_bit = div_cnt_reg[3];
            2'b10:   tap_bit = div_cnt_reg[5];
            default: tap_bit = div_cnt_reg[7];
        endcase
    end

    // DIV clears and TAC changes can drop tick_sig too; those falling edges count.
    assign tick_sig  = tac_reg[2] & tap_bit;
    assign tick_fall = tick_reg & ~tick_sig;

`ifdef TIMER_OVF_DELAY_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OVF,
        ST_RELOAD
    } state_t;

    localparam int          OVF_CYCLES = 4;
    localparam logic [1:0]  OVF_LAST   = 2'(OVF_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] ovf_cnt_reg;
    logic [1:0] ovf_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ovf_cnt_reg <= 2'd0;
        end else begin
            state_reg   <= state_next;
            ovf_cnt_reg <= ovf_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ovf_cnt_next = ovf_cnt_reg;
        tima_next    = tima_reg;
        reload       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_tima) begin
                    tima_next = d_wr;
                end else if (tick_fall) begin
                    if (tima_reg == 8'hFF) begin
                        tima_next    = 8'h00;
                        ovf_cnt_next = 2'd0;
                        state_next   = ST_OVF;
                    end else begin
                        tima_next = tima_reg + 8'd1;
                    end
                end
            end
            ST_OVF: begin
                if (wr_tima) begin
                    tima_next  = d_wr;
                    state_next = ST_IDLE;
                end else if (ovf_cnt_reg == OVF_LAST) begin
                    tima_next  = tma_reg;
                    reload     = 1'b1;
                    state_next = ST_RELOAD;
                end else begin
                    ovf_cnt_next = ovf_cnt_reg + 2'd1;
                end
            end
            ST_RELOAD: begin
                // TIMA writes are swallowed here, but a fresh TMA value still lands in TIMA.
                state_next = ST_IDLE;
                if (wr_tma) begin
                    tima_next = d_wr;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
`else
    always_comb begin
        tima_next = tima_reg;
        reload    = 1'b0;
        if (wr_tima) begin
            tima_next = d_wr;
        end else if (tick_fall) begin
            if (tima_reg == 8'hFF) begin
                tima_next = tma_reg;
                reload    = 1'b1;
            end else begin
                tima_next = tima_reg + 8'd1;
            end
        end
    end
`endif

    // A reload in the same clock as the ack wins, so a new request is never lost.
    assign int_req_next = reload | (int_req_reg & ~int_tim_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= 16'h0000;
            tima_reg    <= 8'h00;
            tma_reg     <= 8'h00;
            tac_reg     <= 3'b000;
            tick_reg    <= 1'b0;
            int_req_reg <= 1'b0;
        end else begin
            div_cnt_reg <= wr_div ? 16'h0000 : div_cnt_reg + 16'd1;
            if (wr_tma) begin
                tma_reg <= d_wr;
            end
            if (wr_tac) begin
                tac_reg <= d_wr[2:0];
            end
            tick_reg    <= tick_sig;
            tima_reg    <= tima_next;
            int_req_reg <= int_req_next;
        end
    end

    always_comb begin
        d_rd = 8'hFF;
        case (a)
            ADDR_DIV:  d_rd = div_cnt_reg[15:8];
            ADDR_TIMA: d_rd = tima_reg;
            ADDR_TMA:  d_rd = tma_reg;
            ADDR_TAC:  d_rd = {5'b11111, tac_reg};
            default:   d_rd = 8'hFF;
        endcase
    end

    assign int_tim_req = int_req_reg;
endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: expectations are queued with a cycle stamp when stimulus
// is driven, then popped and compared at that cycle's falling clock edge.
module tb_timer;
    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;
    localparam logic [15:0] SEL_REQ = 16'h0000;

`ifdef TIMER_OVF_DELAY_EN
    localparam int         DLY         = 4;
    localparam logic [7:0] TIMA_AT_OVF = 8'h00;
    localparam logic [7:0] REQ_AT_OVF  = 8'h00;
`else
    localparam int         DLY         = 0;
    localparam logic [7:0] TIMA_AT_OVF = 8'hF0;
    localparam logic [7:0] REQ_AT_OVF  = 8'h01;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  d_wr;
    logic [7:0]  d_rd;
    logic        rd;
    logic        wr;
    logic        int_tim_req;
    logic        int_tim_ack;

    timer dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .d_wr        (d_wr),
        .d_rd        (d_rd),
        .rd          (rd),
        .wr          (wr),
        .int_tim_req (int_tim_req),
        .int_tim_ack (int_tim_ack)
    );

    typedef struct packed {
        logic [31:0] t;
        logic [15:0] sel;
        logic [7:0]  exp;
    } sb_t;

    sb_t sb_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  base = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1800000;
        $display("FAIL watchdog: cycle %0d reached without finishing, required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_at(input int t, input logic [15:0] s, input logic [7:0] e);
        sb_t ent;
        ent.t   = 32'(t);
        ent.sel = s;
        ent.exp = e;
        sb_q.push_back(ent);
    endtask

    task automatic sample(input logic [15:0] s, output logic [7:0] v);
        if (s == SEL_REQ) begin
            v = {7'd0, int_tim_req};
        end else begin
            a  = s;
            rd = 1'b1;
            #1;
            v  = d_rd;
            rd = 1'b0;
            a  = 16'h0000;
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        a    = addr;
        d_wr = data;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
        a    = 16'h0000;
        d_wr = 8'h00;
        $display("WR  %h <= %h at cycle %0d", addr, data, cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    // Timer at TIMA=FF, TMA=F0, tap bit 3; returns the cycle of the overflowing increment.
    task automatic setup_ovf(output int o);
        do_reset();
        bus_write(A_DIV, 8'h00);
        base = cyc;
        bus_write(A_TAC, 8'h05);
        bus_write(A_TMA, 8'hF0);
        bus_write(A_TIMA, 8'hFF);
        o = base + 17;
    endtask

    task automatic test_reset();
        sb_t e; logic [7:0] got;
        do_reset();
        expect_at(cyc, A_DIV, 8'h00);
        expect_at(cyc, A_TIMA, 8'h00);
        expect_at(cyc, A_TMA, 8'h00);
        expect_at(cyc, A_TAC, 8'hF8);
        expect_at(cyc, SEL_REQ, 8'h00);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL reset cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
        end
    endtask

    task automatic test_count_ovf();
        sb_t e; logic [7:0] got;
        do_reset();
        bus_write(A_DIV, 8'h00);
        base = cyc;
        bus_write(A_TAC, 8'h05);
        bus_write(A_TMA, 8'hF0);
        bus_write(A_TIMA, 8'hFE);
        expect_at(base + 16, A_TIMA, 8'hFE);
        expect_at(base + 16, A_TAC, 8'hFD);
        expect_at(base + 17, A_TIMA, 8'hFF);
        expect_at(base + 32, A_TIMA, 8'hFF);
        expect_at(base + 32, SEL_REQ, 8'h00);
        expect_at(base + 33, A_TIMA, TIMA_AT_OVF);
        expect_at(base + 33, SEL_REQ, REQ_AT_OVF);
`ifdef TIMER_OVF_DELAY_EN
        expect_at(base + 36, A_TIMA, 8'h00);
        expect_at(base + 36, SEL_REQ, 8'h00);
        expect_at(base + 37, A_TIMA, 8'hF0);
        expect_at(base + 37, SEL_REQ, 8'h01);
`endif
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL count_ovf cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
        end
    endtask

    // Continues from test_count_ovf: the reload happened at base+33+DLY.
    task automatic test_int_ack();
        sb_t e; logic [7:0] got;
        int r0;
        int r1;
        r0 = base + 33 + DLY;
        r1 = base + 49 + DLY;
        expect_at(r0 + 2, SEL_REQ, 8'h01);
        expect_at(r0 + 3, SEL_REQ, 8'h00);
        expect_at(base + 48, A_TIMA, 8'hFF);
        expect_at(base + 48, SEL_REQ, 8'h00);
        expect_at(r1, SEL_REQ, 8'h01);
        expect_at(r1, A_TIMA, 8'hF0);
        expect_at(r1 + 1, SEL_REQ, 8'h01);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL int_ack cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
            if (cyc == r0 + 2 && e.sel == SEL_REQ) begin
                int_tim_ack = 1'b1;
                @(negedge clk);
                int_tim_ack = 1'b0;
            end else if (cyc == r0 + 3) begin
                bus_write(A_TIMA, 8'hFF);
            end else if (cyc == base + 48 && e.sel == SEL_REQ) begin
                wait_until(r1 - 1);
                int_tim_ack = 1'b1;
                @(negedge clk);
                int_tim_ack = 1'b0;
            end
        end
    endtask

    task automatic test_glitch_write_wins();
        sb_t e; logic [7:0] got;
        do_reset();
        bus_write(A_DIV, 8'h00);
        base = cyc;
        bus_write(A_TAC, 8'h05);
        bus_write(A_TIMA, 8'h10);
        wait_until(base + 8);
        bus_write(A_DIV, 8'h5A);
        expect_at(base + 9, A_DIV, 8'h00);
        expect_at(base + 9, A_TIMA, 8'h10);
        expect_at(base + 10, A_TIMA, 8'h11);
        expect_at(base + 25, A_TIMA, 8'h11);
        expect_at(base + 26, A_TIMA, 8'h80);
        expect_at(base + 27, A_TIMA, 8'h80);
        expect_at(base + 41, A_TIMA, 8'h80);
        expect_at(base + 42, A_TIMA, 8'h81);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL glitch cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
            if (cyc == base + 25) begin
                bus_write(A_TIMA, 8'h80);
            end
        end
    endtask

    task automatic test_taps();
        sb_t e; logic [7:0] got;
        logic [7:0] tac_tab [5] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h01};
        int         per_tab [5] = '{1024, 16, 64, 256, 0};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            bus_write(A_DIV, 8'h00);
            base = cyc;
            bus_write(A_TAC, tac_tab[i]);
            bus_write(A_TIMA, 8'h00);
            if (per_tab[i] != 0) begin
                expect_at(base + per_tab[i], A_TIMA, 8'h00);
                expect_at(base + per_tab[i] + 1, A_TIMA, 8'h01);
            end else begin
                expect_at(base + 17, A_TIMA, 8'h00);
                expect_at(base + 40, A_TIMA, 8'h00);
            end
            while (sb_q.size() > 0) begin
                wait_until(int'(sb_q[0].t));
                e = sb_q.pop_front();
                sample(e.sel, got);
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL taps tac=%h cyc=%0d got=%h required=%h", tac_tab[i], cyc, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_reg_access();
        sb_t e; logic [7:0] got;
        do_reset();
        bus_write(A_TAC, 8'h02);
        expect_at(cyc, A_TAC, 8'hFA);
        expect_at(cyc, 16'hFF08, 8'hFF);
        expect_at(cyc, 16'hFF03, 8'hFF);
        bus_write(A_TMA, 8'h5A);
        expect_at(cyc, A_TMA, 8'h5A);
        a    = A_TMA;
        d_wr = 8'h11;
        @(negedge clk);
        bus_write(16'hFF16, 8'h77);
        expect_at(cyc, A_TMA, 8'h5A);
        expect_at(cyc, A_TAC, 8'hFA);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL reg_access sel=%h got=%h required=%h", e.sel, got, e.exp);
            end
        end
    endtask

    task automatic test_div_wrap();
        sb_t e; logic [7:0] got;
        do_reset();
        expect_at(base + 255, A_DIV, 8'h00);
        expect_at(base + 256, A_DIV, 8'h01);
        expect_at(base + 65535, A_DIV, 8'hFF);
        expect_at(base + 65536, A_DIV, 8'h00);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL div_wrap cyc=%0d got=%h required=%h", cyc - base, got, e.exp);
            end
        end
    endtask

    task automatic test_ovf_write();
        sb_t e; logic [7:0] got;
        int o;
        setup_ovf(o);
        expect_at(o, A_TIMA, TIMA_AT_OVF);
        expect_at(o + 1, A_TIMA, TIMA_AT_OVF);
        expect_at(o + 2, A_TIMA, 8'h42);
        expect_at(o + 4, SEL_REQ, REQ_AT_OVF);
        expect_at(o + 8, A_TIMA, 8'h42);
        expect_at(o + 8, SEL_REQ, REQ_AT_OVF);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL ovf_write cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
            if (cyc == o + 1) begin
                bus_write(A_TIMA, 8'h42);
            end
        end
    endtask

`ifdef TIMER_OVF_DELAY_EN
    task automatic test_reload_writes();
        sb_t e; logic [7:0] got;
        int o;
        for (int k = 0; k < 2; k++) begin
            setup_ovf(o);
            expect_at(o + 4, A_TIMA, 8'hF0);
            expect_at(o + 5, A_TIMA, (k == 0) ? 8'hF0 : 8'h33);
            expect_at(o + 6, A_TIMA, (k == 0) ? 8'hF0 : 8'h33);
            while (sb_q.size() > 0) begin
                wait_until(int'(sb_q[0].t));
                e = sb_q.pop_front();
                sample(e.sel, got);
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL reload_write k=%0d cyc=%0d got=%h required=%h", k, cyc, got, e.exp);
                end
                if (cyc == o + 4) begin
                    bus_write((k == 0) ? A_TIMA : A_TMA, (k == 0) ? 8'h99 : 8'h33);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_ovf();
        sb_t e; logic [7:0] got;
        int o;
        setup_ovf(o);
        expect_at(o + 1, A_TIMA, TIMA_AT_OVF);
        expect_at(o + 1, SEL_REQ, REQ_AT_OVF);
        expect_at(o + 2, A_DIV, 8'h00);
        expect_at(o + 2, A_TIMA, 8'h00);
        expect_at(o + 2, A_TMA, 8'h00);
        expect_at(o + 2, A_TAC, 8'hF8);
        for (int k = 2; k <= 8; k++) expect_at(o + k, SEL_REQ, 8'h00);
        expect_at(o + 8, A_TIMA, 8'h00);
        while (sb_q.size() > 0) begin
            wait_until(int'(sb_q[0].t));
            e = sb_q.pop_front();
            sample(e.sel, got);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL reset_ovf cyc=%0d sel=%h got=%h required=%h", cyc, e.sel, got, e.exp);
            end
            if (cyc == o + 1 && e.sel == SEL_REQ) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        a           = 16'h0000;
        d_wr        = 8'h00;
        rd          = 1'b0;
        wr          = 1'b0;
        int_tim_ack = 1'b0;
        test_reset();
        test_count_ovf();
        test_int_ack();
        test_glitch_write_wins();
        test_taps();
        test_reg_access();
        test_ovf_write();
`ifdef TIMER_OVF_DELAY_EN
        test_reload_writes();
`endif
        test_reset_ovf();
        test_div_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have port: clk  input  1  4.19 MHz system clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: a  input  16  bus address.
REQ-004 SHALL have port: d_wr  input  8  bus write data.
REQ-005 SHALL have port: d_rd  output  8  bus read data.
REQ-006 SHALL have port: rd  input  1  bus read strobe.
REQ-007 SHALL have port: wr  input  1  bus write strobe.
REQ-008 SHALL have port: int_tim_req  output  1  timer interrupt request (IF bit 2).
REQ-009 SHALL have port: int_tim_ack  input  1  interrupt acknowledge, i.e. IF bit 2 observed set.
REQ-010 SHALL have parameter: none; the register map is fixed at DIV=FF04, TIMA=FF05, TMA=FF06, TAC=FF07.

Function
REQ-011 SHALL keep a 16-bit free-running counter div_cnt, incremented by 1 every clk and wrapping FFFF->0000; DIV reads div_cnt[15:8].
REQ-012 SHALL clear all 16 bits of div_cnt on any write to FF04; the written data is ignored.
REQ-013 SHALL decode TAC[1:0] to a tap bit of div_cnt: 00->bit 9 (4096 Hz), 01->bit 3, 10->bit 5, 11->bit 7.
REQ-014 SHALL form tick_sig = TAC[2] & div_cnt[tap] and register it every clk; TIMA SHALL increment when the registered value is 1 and the current value is 0 (falling edge).
REQ-015 SHALL therefore also increment TIMA on falling edges caused by a DIV write or a TAC write (DMG glitch behaviour).
REQ-016 SHALL hold the overflow FSM in IDLE except after an increment of TIMA=FF, which sets TIMA=00 and enters OVF.
REQ-017 In OVF, SHALL keep TIMA=00 for OVF_CYCLES clocks, then spend one clock in RELOAD: TIMA<=TMA, int_tim_req<=1, then return to IDLE.
REQ-018 SHALL, on a CPU write to TIMA while in OVF, load the written value, cancel the reload and the interrupt, and return to IDLE.
REQ-019 SHALL ignore a CPU write to TIMA in the RELOAD clock; a TMA write in that same clock SHALL make TIMA load the new TMA value.
REQ-020 SHALL, on a CPU write to TIMA in IDLE, load d_wr; a tick edge in the same clock is discarded (the write wins).
REQ-021 SHALL drive d_rd combinationally: FF04->div_cnt[15:8], FF05->TIMA, FF06->TMA, FF07->{5'b11111,TAC[2:0]}, any other address->8'hFF; rd does not gate d_rd.
REQ-022 SHALL latch register writes only when wr=1 and a matches the register address.
REQ-023 SHALL hold int_tim_req at 1 from RELOAD until the first clk with int_tim_ack=1, then clear it; a new RELOAD in the same clock as the ack SHALL keep it at 1.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, set div_cnt=0000, TIMA=00, TMA=00, TAC=0, tick register=0, FSM=IDLE and int_tim_req=0.
REQ-025 SHALL let rst abort OVF/RELOAD with no reload and no interrupt.

Configuration
REQ-026 SHALL honour macro TIMER_OVF_DELAY_EN: when defined, OVF_CYCLES=4 and REQ-017 to REQ-019 apply.
REQ-027 SHALL, without TIMER_OVF_DELAY_EN, reload TIMA<=TMA and set int_tim_req in the same clock as the overflowing increment, with no OVF/RELOAD states and no write-cancel window.

Verification
REQ-028 SHALL cover: TAC=05 (enabled, tap bit 3), TMA=F0, TIMA=FE -> TIMA increments every 16 clk; 4 clk after the FF->00 wrap (macro on), TIMA=F0 and int_tim_req=1.
REQ-029 SHALL cover: during OVF, write TIMA=0x42 -> TIMA=42, no reload, int_tim_req stays 0.
REQ-030 SHALL cover: div_cnt=0x0008 with TAC=05, write FF04 -> div_cnt=0000 and TIMA increments once (glitch tick).
REQ-031 SHALL cover: int_tim_req=1, pulse int_tim_ack for 1 clk -> req=0 on the next clk; a RELOAD coincident with the ack -> req remains 1.
REQ-032 SHALL cover: read FF07 with TAC=02 -> d_rd=FA; read FF08 -> FF; 65536 clk from reset -> DIV wraps FF->00.
REQ-033 SHALL cover: rst asserted mid-OVF -> all registers 0 next clk, int_tim_req never asserts.
